layer_tick_scheduler: RTL and testbench
=======================================

// Module: layer_tick_scheduler
// PURPOSE
//  Run-time programmable replacement for the fixed layer clock divider: sequences per-layer
//  processing ticks for the ODESA hierarchy from the single system clock. Emits one-cycle tick
//  enables plus 50% level clocks per layer; periods programmable; start/stop FSM.
//  Stalls a layer tick while that layer reports busy. Sits between top-level control and layers.
// PARAMETERS
//  P_NUM_LVL    2     number of layers/levels scheduled
//  P_CNT_W      16    period counter width; max period 2**P_CNT_W-1
//  P_DEF_PER_1  780   reset period of level 0, in i_clk cycles
//  P_DEF_PER_2  2000  reset period of level 1, in i_clk cycles
// PORTS
//  i_clk         in   1          system clock; all logic on posedge
//  i_rst_n       in   1          asynchronous active-low reset
//  i_cfg_we      in   1          period write strobe, one cycle
//  i_cfg_lvl     in   $clog2(P_NUM_LVL)  level index for write; out-of-range write ignored
//  i_cfg_period  in   P_CNT_W    new period in cycles
//  i_start       in   1          pulse: IDLE->RUN
//  i_stop        in   1          pulse: RUN->DRAIN
//  i_lvl_busy    in   P_NUM_LVL  per-level busy from layer logic
//  o_tick        out  P_NUM_LVL  one-cycle tick enable per level
//  o_clk_lvl     out  P_NUM_LVL  per-level 50% level clock
//  o_overrun     out  P_NUM_LVL  sticky: tick was stalled by busy
//  o_running     out  1          high in RUN or DRAIN
// BEHAVIOUR
//  Reset: state IDLE; counters 0; active and shadow periods = defaults; all outputs 0.
//  FSM IDLE: counters held 0, o_tick=0, o_clk_lvl=0. i_start -> RUN next cycle.
//    Same-cycle i_start with i_stop in IDLE: stay IDLE. i_start clears o_overrun.
//  FSM RUN: per-level counter runs 0..period-1, wraps to 0. Terminal = (cnt==period-1).
//    At terminal with busy[l]=0: o_tick[l]=1 for that cycle, counter wraps.
//    At terminal with busy[l]=1: counter holds at period-1, tick pending, o_overrun[l] set;
//      tick fires first cycle busy[l]=0, then counter wraps. Tick latency from busy fall: 0.
//    i_stop -> DRAIN next cycle. i_start in RUN ignored.
//  FSM DRAIN: counters frozen, no new ticks except pending ones (issued when busy drops);
//    when no pending tick and i_lvl_busy==0 -> IDLE next cycle (counters reset to 0).
//  o_clk_lvl[l] = 0 while cnt < (period>>1), else 1; registered with counter. Held 0 in IDLE.
//  Config: i_cfg_we loads shadow period; in IDLE copied to active immediately (next cycle);
//    in RUN/DRAIN copied only on that level's wrap, so a period never changes mid-cycle.
//    Written period < 2 clamped to 2. Two writes before a wrap: last wins.
//  Simultaneous wrap and i_cfg_we same level: wrap uses old shadow; new value at next wrap.
//  o_running=1 in RUN and DRAIN. Async reset mid-operation: immediate return to reset state.
//  Levels are independent: no phase alignment between levels after start (all start at cnt=0).
// STRUCTURE
//  Package layer_sched_pkg: state enum {ST_IDLE, ST_RUN, ST_DRAIN}, MIN_PERIOD=2,
//    default period constants.
//  Sub-module tick_counter (one instance per level via generate):
//    - holds shadow/active period, counter, pending flag, overrun bit;
//    - run/freeze/clear controls from the top-level FSM.
//  Top level: FSM, config decode, output OR of pending flags.
// TESTING
//  1 Reset, i_start, no cfg: o_tick[0] every 780 cycles, first at cycle 780 after RUN entry;
//    o_tick[1] every 2000; o_clk_lvl[0] high for cnt 390..779.
//  2 Write level0 period=10 in RUN at cnt 3: current cycle keeps 780; next period is 10.
//  3 Busy stall: hold busy[0]=1 over terminal for 5 cycles -> tick delayed 5 cycles,
//    o_overrun[0]=1, level 1 unaffected.
//  4 i_stop with busy[1]=1 and pending tick -> DRAIN; tick fires on busy fall, next cycle IDLE.
//    o_running falls.
//  5 Write period=0 and 1 -> effective period 2: tick every other cycle, o_clk_lvl toggles.
//  6 Assert i_rst_n low mid-RUN -> outputs 0 immediately, periods back to 780/2000,
//    state IDLE.

Source files
------------

// File: rtl/layer_sched_pkg.sv
// layer_sched_pkg: shared FSM encoding and period constants for the layer tick scheduler
package layer_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;
  localparam int MIN_PERIOD = 2;
  localparam int DEF_PER_1  = 780;
  localparam int DEF_PER_2  = 2000;
endpackage

// File: rtl/tick_counter.sv
// tick_counter: one level's period counter with shadowed period, stall/pending tick and sticky overrun
module tick_counter
  import layer_sched_pkg::*;
#(
  parameter int P_CNT_W = 16,
  parameter int P_DEF   = DEF_PER_1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_drain,
  input  logic               i_clr,
  input  logic               i_idle,
  input  logic               i_clr_ovr,
  input  logic               i_we,
  input  logic [P_CNT_W-1:0] i_period,
  input  logic               i_busy,
  output logic               o_tick,
  output logic               o_clk_lvl,
  output logic               o_overrun
);
  logic [P_CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic               pend_q, pend_d, ovr_q, ovr_d, clk_q, clk_d, term, stall;
  always_comb begin
    term   = cnt_q == act_q - 1'b1;
    stall  = i_run & term & i_busy;
    o_tick = ((i_run & term) | (i_drain & pend_q)) & ~i_busy;
    cnt_d  = (i_clr | o_tick) ? '0 : (i_run & ~term) ? cnt_q + 1'b1 : cnt_q;
    pend_d = ~i_clr & (stall | (pend_q & ~o_tick));
    ovr_d  = ~i_clr_ovr & (ovr_q | stall);
    shd_d  = i_we ? i_period : shd_q;
    // the wrap takes the shadow as it stood before any same-cycle write
    act_d  = (i_idle & i_we) ? i_period : o_tick ? shd_q : act_q;
    clk_d  = cnt_d >= (act_d >> 1);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      act_q  <= P_CNT_W'(P_DEF);
      shd_q  <= P_CNT_W'(P_DEF);
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      clk_q  <= clk_d;
    end
  end
  assign o_clk_lvl = clk_q;
  assign o_overrun = ovr_q;
endmodule

// File: rtl/layer_tick_scheduler.sv
// layer_tick_scheduler: start/stop FSM sequencing programmable per-layer tick enables and level clocks
module layer_tick_scheduler
  import layer_sched_pkg::*;
#(
  parameter  int P_NUM_LVL   = 2,
  parameter  int P_CNT_W     = 16,
  parameter  int P_DEF_PER_1 = DEF_PER_1,
  parameter  int P_DEF_PER_2 = DEF_PER_2,
  localparam int LVL_W       = P_NUM_LVL > 1 ? $clog2(P_NUM_LVL) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cfg_we,
  input  logic [LVL_W-1:0]     i_cfg_lvl,
  input  logic [P_CNT_W-1:0]   i_cfg_period,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [P_NUM_LVL-1:0] i_lvl_busy,
  output logic [P_NUM_LVL-1:0] o_tick,
  output logic [P_NUM_LVL-1:0] o_clk_lvl,
  output logic [P_NUM_LVL-1:0] o_overrun,
  output logic                 o_running
);
  state_e             state_q, state_d;
  logic [P_CNT_W-1:0] per_clamped;
  always_comb begin
    state_d = (state_q == ST_IDLE && i_start && !i_stop) ? ST_RUN :
              (state_q == ST_RUN && i_stop)              ? ST_DRAIN :
              (state_q == ST_DRAIN && ~|i_lvl_busy)      ? ST_IDLE : state_q;
    per_clamped = (i_cfg_period < P_CNT_W'(MIN_PERIOD)) ? P_CNT_W'(MIN_PERIOD) : i_cfg_period;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end
  assign o_running = state_q != ST_IDLE;
  // levels beyond the second reuse the second default period
  for (genvar i = 0; i < P_NUM_LVL; i++) begin : g_lvl
    tick_counter #(
      .P_CNT_W (P_CNT_W),
      .P_DEF   (i == 0 ? P_DEF_PER_1 : P_DEF_PER_2)
    ) u_cnt (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_run     (state_q == ST_RUN),
      .i_drain   (state_q == ST_DRAIN),
      .i_clr     (state_d == ST_IDLE),
      .i_idle    (state_q == ST_IDLE),
      .i_clr_ovr (state_q == ST_IDLE && i_start),
      .i_we      (i_cfg_we && i_cfg_lvl == LVL_W'(i)),
      .i_period  (per_clamped),
      .i_busy    (i_lvl_busy[i]),
      .o_tick    (o_tick[i]),
      .o_clk_lvl (o_clk_lvl[i]),
      .o_overrun (o_overrun[i])
    );
  end
endmodule

// File: tb/tb_layer_tick_scheduler.sv
// tb_layer_tick_scheduler: directed scenarios checked against a cycle-level behavioural model
module tb_layer_tick_scheduler;
  logic        clk = 0, rst_n = 0, cfg_we = 0, cfg_lvl = 0, start = 0, stop = 0;
  logic [15:0] cfg_period = 0;
  logic [1:0]  busy = 0, tick, clk_lvl, ovr;
  logic        running;
  int          checks = 0, errors = 0;

  layer_tick_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_lvl(cfg_lvl),
    .i_cfg_period(cfg_period), .i_start(start), .i_stop(stop), .i_lvl_busy(busy),
    .o_tick(tick), .o_clk_lvl(clk_lvl), .o_overrun(ovr), .o_running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // model: mode 0 idle, 1 run, 2 drain; pos is the position within the current period
  int   m_mode = 0, m_pos[2], m_per[2], m_shd[2], nv;
  bit   m_pend[2], m_ovr[2], stall, wr;
  logic [1:0] e_tick, e_clk, e_ovr;

  function automatic void m_reset();
    m_mode = 0;
    for (int l = 0; l < 2; l++) begin
      m_pos[l] = 0; m_per[l] = l == 0 ? 780 : 2000; m_shd[l] = m_per[l];
      m_pend[l] = 0; m_ovr[l] = 0;
    end
  endfunction

  initial m_reset();

  always @(negedge clk) begin
    if (!rst_n) m_reset();
    for (int l = 0; l < 2; l++) begin
      e_tick[l] = ((m_mode == 1 && m_pos[l] == m_per[l] - 1) || (m_mode == 2 && m_pend[l])) && !busy[l];
      e_clk[l]  = m_mode != 0 && m_pos[l] >= m_per[l] / 2;
      e_ovr[l]  = m_ovr[l];
    end
    check("model_tick", tick, e_tick);
    check("model_clk_lvl", clk_lvl, e_clk);
    check("model_overrun", ovr, e_ovr);
    check("model_running", running, m_mode != 0);
    if (rst_n) begin
      for (int l = 0; l < 2; l++) begin
        stall = m_mode == 1 && m_pos[l] == m_per[l] - 1 && busy[l];
        wr    = cfg_we && cfg_lvl == l;
        nv    = cfg_period < 2 ? 2 : cfg_period;
        if (e_tick[l]) begin m_pos[l] = 0; m_per[l] = m_shd[l]; m_pend[l] = 0; end
        else if (m_mode == 1 && !stall) m_pos[l]++;
        if (stall) begin m_pend[l] = 1; m_ovr[l] = 1; end
        if (wr) begin m_shd[l] = nv; if (m_mode == 0) m_per[l] = nv; end
        if (m_mode == 0 && start) m_ovr[l] = 0;
      end
      case (m_mode)
        0:       if (start && !stop) m_mode = 1;
        1:       if (stop) m_mode = 2;
        default: if (busy == 0) m_mode = 0;
      endcase
      if (m_mode == 0) for (int l = 0; l < 2; l++) begin m_pos[l] = 0; m_pend[l] = 0; end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // n = cycles until the tick (counting the current cycle as 1), hi = cycles with level clock high
  task automatic wait_tick(input int l, input int lim, output int n, output int hi);
    n = 0; hi = 0;
    do begin
      @(negedge clk); n++;
      if (clk_lvl[l]) hi++;
    end while (!tick[l] && n < lim);
  endtask

  initial begin
    int n, hi;
    repeat (3) step();
    rst_n = 1;
    @(negedge clk);
    check("rst_tick", tick, 0); check("rst_clk", clk_lvl, 0);
    check("rst_ovr", ovr, 0);   check("rst_running", running, 0);
    // default periods after start
    step(); start = 1; step(); start = 0;
    wait_tick(0, 2000, n, hi); check("t1_first_tick0", n, 780); check("t1_clk_hi0", hi, 390);
    wait_tick(0, 2000, n, hi); check("t1_tick0_period", n, 780);
    wait_tick(1, 2000, n, hi); check("t1_first_tick1", n, 440);
    wait_tick(1, 2100, n, hi); check("t1_tick1_period", n, 2000);
    // period write in RUN applies only from the next wrap
    wait_tick(0, 2000, n, hi); check("t2_align", n, 680);
    repeat (4) step();
    cfg_we = 1; cfg_lvl = 0; cfg_period = 10;
    step(); cfg_we = 0;
    wait_tick(0, 2000, n, hi); check("t2_old_period", n, 776);
    wait_tick(0, 100, n, hi);  check("t2_new_period", n, 10); check("t2_clk_hi", hi, 5);
    wait_tick(0, 100, n, hi);  check("t2_new_period2", n, 10);
    // five-cycle busy stall over level 0 terminal
    repeat (10) step();
    busy[0] = 1;
    @(negedge clk); check("t3_stalled", tick[0], 0);
    step();
    @(negedge clk); check("t3_ovr0", ovr[0], 1); check("t3_ovr1", ovr[1], 0);
    repeat (4) step();
    busy[0] = 0;
    @(negedge clk); check("t3_late_tick", tick[0], 1);
    wait_tick(0, 100, n, hi); check("t3_after_stall", n, 10);
    // stop while level 1 holds a pending tick
    step(); cfg_we = 1; cfg_lvl = 1; cfg_period = 6;
    step(); cfg_we = 0;
    wait_tick(1, 2100, n, hi); check("t4_align", tick[1], 1);
    step(); busy[1] = 1;
    repeat (7) step();
    stop = 1; step(); stop = 0;
    @(negedge clk); check("t4_drain_running", running, 1); check("t4_drain_hold", tick[1], 0);
    repeat (2) step();
    busy[1] = 0;
    @(negedge clk); check("t4_drain_tick", tick[1], 1);
    step();
    @(negedge clk); check("t4_idle", running, 0); check("t4_ovr1", ovr[1], 1);
    // start with stop in IDLE stays IDLE but clears overrun
    step(); start = 1; stop = 1; step(); start = 0; stop = 0;
    @(negedge clk); check("idle_startstop", running, 0); check("idle_ovr_clr", ovr, 0);
    // periods below the minimum clamp to 2
    step(); cfg_we = 1; cfg_lvl = 0; cfg_period = 0;
    step(); cfg_lvl = 1; cfg_period = 1;
    step(); cfg_we = 0; start = 1;
    step(); start = 0;
    wait_tick(0, 10, n, hi); check("t5_per0", n, 2); check("t5_hi0", hi, 1);
    wait_tick(1, 10, n, hi); check("t5_per1", n, 2); check("t5_hi1", hi, 1);
    // asynchronous reset mid-run
    step(); step();
    check("t6_pre_clk", clk_lvl, 3);
    rst_n = 0; #1;
    check("t6_tick", tick, 0); check("t6_clk", clk_lvl, 0); check("t6_running", running, 0);
    repeat (2) step();
    rst_n = 1;
    step(); start = 1; step(); start = 0;
    wait_tick(0, 1000, n, hi); check("t6_def0", n, 780); check("t6_hi0", hi, 390);
    wait_tick(1, 2100, n, hi); check("t6_def1", n, 1220);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule
